alu_exec_unit: RTL and testbench

ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

---
 rtl/alu_exec_unit.sv | 207 ++++++++++++++++++++
 tb/tb_alu_exec_unit.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/alu_exec_unit.sv
// ---------------------------------------------------------------------------
// alu_exec_unit
// Single-cycle-latency ALU execute stage. The main-decoder class (alu_op) and
// funct bits are decoded combinationally into a 4-bit operation code. The
// result and flags are registered on the rising clock edge when in_valid is
// high. They hold their values when in_valid is low.
//
// Ports
//   clk        in   1      rising-edge clock
//   reset      in   1      synchronous active-high reset
//   in_valid   in   1      operands/controls valid this cycle
//   alu_op     in   2      00 load/store, 01 branch, 10 R-type, 11 reserved
//   funct      in   4      {instr[30], instr[14:12]}
//   a          in   WIDTH  operand 1 (rs1)
//   b          in   WIDTH  operand 2 (rs2 or immediate)
//   out_valid  out  1      in_valid delayed by one cycle
//   result     out  WIDTH  registered ALU result
//   zero       out  1      registered (result == 0)
//   cout       out  1      registered adder carry-out (ADD/SUB only)
//   overflow   out  1      registered signed overflow (ADD/SUB only)
// ---------------------------------------------------------------------------
module alu_exec_unit #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [1:0]       alu_op,
    input  logic [3:0]       funct,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             cout,
    output logic             overflow
);

    localparam int NG  = WIDTH / 4;
    localparam int SHW = $clog2(WIDTH);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_XOR  = 4'b0011;
    localparam logic [3:0] OP_SLL  = 4'b0100;
    localparam logic [3:0] OP_SRL  = 4'b0101;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_SLTU = 4'b1000;
    localparam logic [3:0] OP_SRA  = 4'b1001;

    // Carry-lookahead adder. Each 4-bit group produces a group generate and a
    // group propagate. The carry into every group is formed directly from those
    // group terms, so no ripple occurs between groups.
    // Returns {carry_out, carry_into_msb, sum}.
    function automatic logic [WIDTH+1:0] cla_add(
        input logic [WIDTH-1:0] x,
        input logic [WIDTH-1:0] y,
        input logic             cin
    );
        logic [WIDTH-1:0] g;
        logic [WIDTH-1:0] p;
        logic [WIDTH:0]   c;
        logic [NG-1:0]    gg;
        logic [NG-1:0]    gp;
        logic [NG:0]      gc;
        logic             term_or;
        logic             pr;
        g = x & y;
        p = x ^ y;
        for (int k = 0; k < NG; k++) begin
            gg[k] = g[4*k+3]
                  | (p[4*k+3] & g[4*k+2])
                  | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                  | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
            gp[k] = p[4*k+3] & p[4*k+2] & p[4*k+1] & p[4*k];
        end
        gc[0] = cin;
        for (int i = 1; i <= NG; i++) begin
            term_or = 1'b0;
            for (int j = 0; j < i; j++) begin
                pr = gg[j];
                for (int k = j + 1; k < i; k++) begin
                    pr = pr & gp[k];
                end
                term_or = term_or | pr;
            end
            pr = cin;
            for (int k = 0; k < i; k++) begin
                pr = pr & gp[k];
            end
            gc[i] = term_or | pr;
        end
        // Within a group the carries are formed from the group carry-in.
        for (int k = 0; k < NG; k++) begin
            c[4*k] = gc[k];
            for (int m = 0; m < 3; m++) begin
                c[4*k+m+1] = g[4*k+m] | (p[4*k+m] & c[4*k+m]);
            end
        end
        c[WIDTH] = gc[NG];
        return {c[WIDTH], c[WIDTH-1], p ^ c[WIDTH-1:0]};
    endfunction

    logic [3:0]       w_op;
    logic             w_sub;
    logic [WIDTH+1:0] w_add;
    logic [WIDTH-1:0] w_sum;
    logic             w_carry;
    logic             w_ovf;
    logic [SHW-1:0]   w_shamt;
    logic [WIDTH-1:0] w_result;
    logic             w_cout;
    logic             w_overflow;

    logic             r_out_valid;
    logic [WIDTH-1:0] r_result;
    logic             r_zero;
    logic             r_cout;
    logic             r_overflow;

    // Control decode: main-decoder class plus funct to an ALU operation code.
    always_comb begin
        w_op = OP_ADD;
        case (alu_op)
            2'b00: w_op = OP_ADD;
            2'b01: w_op = OP_SUB;
            2'b10: begin
                case (funct)
                    4'b0000: w_op = OP_ADD;
                    4'b1000: w_op = OP_SUB;
                    4'b0111: w_op = OP_AND;
                    4'b0110: w_op = OP_OR;
                    4'b0100: w_op = OP_XOR;
                    4'b0001: w_op = OP_SLL;
                    4'b0101: w_op = OP_SRL;
                    4'b1101: w_op = OP_SRA;
                    4'b0010: w_op = OP_SLT;
                    4'b0011: w_op = OP_SLTU;
                    default: w_op = OP_ADD;
                endcase
            end
            default: w_op = OP_ADD;
        endcase
    end

    // SLT and SLTU are derived from the subtract path, so they also invert b.
    assign w_sub   = (w_op == OP_SUB) || (w_op == OP_SLT) || (w_op == OP_SLTU);
    assign w_add   = cla_add(a, w_sub ? ~b : b, w_sub);
    assign w_sum   = w_add[WIDTH-1:0];
    assign w_carry = w_add[WIDTH+1];
    // Signed overflow: the carry into the sign bit differs from the carry out of it.
    assign w_ovf   = w_add[WIDTH+1] ^ w_add[WIDTH];
    assign w_shamt = b[SHW-1:0];

    // Result and flag selection for the decoded operation.
    always_comb begin
        w_result   = {WIDTH{1'b0}};
        w_cout     = 1'b0;
        w_overflow = 1'b0;
        case (w_op)
            OP_ADD, OP_SUB: begin
                w_result   = w_sum;
                w_cout     = w_carry;
                w_overflow = w_ovf;
            end
            OP_AND:  w_result = a & b;
            OP_OR:   w_result = a | b;
            OP_XOR:  w_result = a ^ b;
            OP_SLL:  w_result = a << w_shamt;
            OP_SRL:  w_result = a >> w_shamt;
            OP_SRA:  w_result = $signed(a) >>> w_shamt;
            // Signed less-than is the difference sign corrected by overflow.
            OP_SLT:  w_result = {{(WIDTH-1){1'b0}}, w_sum[WIDTH-1] ^ w_ovf};
            // Unsigned less-than is a borrow, that is, no carry out of a + ~b + 1.
            OP_SLTU: w_result = {{(WIDTH-1){1'b0}}, ~w_carry};
            default: w_result = w_sum;
        endcase
    end

    // Output registers: reset wins. Capture on in_valid, otherwise hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_result    <= {WIDTH{1'b0}};
            r_zero      <= 1'b0;
            r_cout      <= 1'b0;
            r_overflow  <= 1'b0;
        end else if (in_valid) begin
            r_out_valid <= 1'b1;
            r_result    <= w_result;
            r_zero      <= (w_result == {WIDTH{1'b0}});
            r_cout      <= w_cout;
            r_overflow  <= w_overflow;
        end else begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign zero      = r_zero;
    assign cout      = r_cout;
    assign overflow  = r_overflow;

endmodule

// File: tb/tb_alu_exec_unit.sv
module tb_alu_exec_unit;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [1:0]  alu_op;
    logic [3:0]  funct;
    logic [63:0] a;
    logic [63:0] b;
    logic        out_valid;
    logic [63:0] result;
    logic        zero;
    logic        cout;
    logic        overflow;

    int n_checks;
    int n_pass;

    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] MSB  = 64'h8000_0000_0000_0000;
    localparam logic [63:0] MAXP = 64'h7FFF_FFFF_FFFF_FFFF;

    alu_exec_unit #(.WIDTH(64)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .alu_op   (alu_op),
        .funct    (funct),
        .a        (a),
        .b        (b),
        .out_valid(out_valid),
        .result   (result),
        .zero     (zero),
        .cout     (cout),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    // Apply one set of inputs for one clock edge, then wait past the edge.
    task automatic step(input logic rst, input logic v, input logic [1:0] op,
                        input logic [3:0] f, input logic [63:0] x, input logic [63:0] y);
        @(negedge clk);
        reset    = rst;
        in_valid = v;
        alu_op   = op;
        funct    = f;
        a        = x;
        b        = y;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic ov, input logic [63:0] r,
                           input logic z, input logic c, input logic o);
        chk({tag, ".out_valid"}, {63'd0, out_valid}, {63'd0, ov});
        chk({tag, ".result"},    result,             r);
        chk({tag, ".zero"},      {63'd0, zero},      {63'd0, z});
        chk({tag, ".cout"},      {63'd0, cout},      {63'd0, c});
        chk({tag, ".overflow"},  {63'd0, overflow},  {63'd0, o});
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        reset    = 1'b1;
        in_valid = 1'b0;
        alu_op   = 2'b00;
        funct    = 4'b0000;
        a        = 64'd0;
        b        = 64'd0;

        step(1'b1, 1'b0, 2'b00, 4'b0000, 64'd0, 64'd0);
        chk_all("reset", 1'b0, 64'd0, 1'b0, 1'b0, 1'b0);

        // The first valid output after reset appears one cycle after in_valid.
        step(1'b0, 1'b1, 2'b00, 4'b0000, 64'd5, 64'd7);
        chk_all("add_5_7", 1'b1, 64'd12, 1'b0, 1'b0, 1'b0);

        step(1'b0, 1'b1, 2'b01, 4'b0000, 64'd5, 64'd5);
        chk_all("sub_5_5", 1'b1, 64'd0, 1'b1, 1'b1, 1'b0);

        step(1'b0, 1'b1, 2'b10, 4'b0111, 64'hF0F0, 64'hFF00);
        chk_all("and", 1'b1, 64'hF000, 1'b0, 1'b0, 1'b0);

        step(1'b0, 1'b1, 2'b10, 4'b0110, 64'hF0F0, 64'hFF00);
        chk_all("or", 1'b1, 64'hFFF0, 1'b0, 1'b0, 1'b0);

        step(1'b0, 1'b1, 2'b10, 4'b0100, 64'hF0F0, 64'hFF00);
        chk_all("xor", 1'b1, 64'h0FF0, 1'b0, 1'b0, 1'b0);

        step(1'b0, 1'b1, 2'b00, 4'b0000, MAXP, 64'd1);
        chk_all("add_ovf", 1'b1, MSB, 1'b0, 1'b0, 1'b1);

        step(1'b0, 1'b1, 2'b00, 4'b0000, ONES, 64'd1);
        chk_all("add_wrap", 1'b1, 64'd0, 1'b1, 1'b1, 1'b0);

        step(1'b0, 1'b1, 2'b10, 4'b1000, 64'd3, 64'd5);
        chk_all("sub_borrow", 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1'b0);

        step(1'b0, 1'b1, 2'b10, 4'b1000, MSB, 64'd1);
        chk_all("sub_ovf", 1'b1, MAXP, 1'b0, 1'b1, 1'b1);

        step(1'b0, 1'b1, 2'b10, 4'b0001, 64'd1, 64'd63);
        chk_all("sll_63", 1'b1, MSB, 1'b0, 1'b0, 1'b0);

        // Only b[5:0] is used as the shift amount.
        step(1'b0, 1'b1, 2'b10, 4'b0001, 64'd1, 64'h44);
        chk_all("sll_trunc", 1'b1, 64'h10, 1'b0, 1'b0, 1'b0);

        step(1'b0, 1'b1, 2'b10, 4'b0101, MSB, 64'd63);
        chk_all("srl_63", 1'b1, 64'd1, 1'b0, 1'b0, 1'b0);

        step(1'b0, 1'b1, 2'b10, 4'b1101, MSB, 64'd63);
        chk_all("sra_63", 1'b1, ONES, 1'b0, 1'b0, 1'b0);

        step(1'b0, 1'b1, 2'b10, 4'b0010, ONES, 64'd1);
        chk_all("slt_m1_1", 1'b1, 64'd1, 1'b0, 1'b0, 1'b0);

        step(1'b0, 1'b1, 2'b10, 4'b0011, ONES, 64'd1);
        chk_all("sltu_m1_1", 1'b1, 64'd0, 1'b1, 1'b0, 1'b0);

        step(1'b0, 1'b1, 2'b10, 4'b0010, MSB, 64'd1);
        chk_all("slt_ovf", 1'b1, 64'd1, 1'b0, 1'b0, 1'b0);

        step(1'b0, 1'b1, 2'b11, 4'b1000, 64'd2, 64'd3);
        chk_all("reserved_add", 1'b1, 64'd5, 1'b0, 1'b0, 1'b0);

        step(1'b0, 1'b1, 2'b10, 4'b1111, 64'd10, 64'd20);
        chk_all("funct_dflt", 1'b1, 64'd30, 1'b0, 1'b0, 1'b0);

        step(1'b0, 1'b1, 2'b01, 4'b0111, 64'd9, 64'd4);
        chk_all("branch_sub", 1'b1, 64'd5, 1'b0, 1'b1, 1'b0);

        // Load a result with overflow set so that the hold is visible.
        step(1'b0, 1'b1, 2'b00, 4'b0000, MAXP, MAXP);
        chk_all("add_ovf2", 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1'b1);

        step(1'b0, 1'b0, 2'b00, 4'b0000, 64'd1, 64'd1);
        chk_all("hold", 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1'b1);

        step(1'b1, 1'b1, 2'b00, 4'b0000, ONES, 64'd1);
        chk_all("reset_prio", 1'b0, 64'd0, 1'b0, 1'b0, 1'b0);

        step(1'b0, 1'b0, 2'b00, 4'b0000, ONES, 64'd1);
        chk_all("post_reset_idle", 1'b0, 64'd0, 1'b0, 1'b0, 1'b0);

        step(1'b0, 1'b1, 2'b00, 4'b0000, 64'd1, 64'd1);
        chk_all("first_after_reset", 1'b1, 64'd2, 1'b0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
